// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT frame driver.
//   complex_t : packed {re, im}, 18-bit signed Q1.17 each
//   state_t   : frame driver states FILL / ARM / RUN / DRAIN
//   bitrev4   : 4-bit bit reversal used to place samples in the core's input order
package fft_pkg;

  localparam int N_PTS  = 16;
  localparam int LOG2_N = 4;
  localparam int CPLX_W = 36;

  typedef struct packed {
    logic signed [17:0] re;
    logic signed [17:0] im;
  } complex_t;

  typedef enum logic [1:0] {FILL, ARM, RUN, DRAIN} state_t;

  function automatic logic [LOG2_N-1:0] bitrev4(input logic [LOG2_N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_bin_serializer.sv
// fft_bin_serializer: captures the 16 FFT bins on i_capture and drains them
// one per valid/ready handshake, in bin order.
// Optional build macro FFT_MAG_EN: present |re|+|im| (saturated, unsigned)
// in the low 18 bits instead of the raw complex word.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_capture       load all bins from i_fft_out and start presenting bin 0
//   i_fft_out       16 x 36-bit bins, slot j at [36j+35:36j]
//   i_m_ready       downstream ready
//   o_m_valid       bin stream valid
//   o_m_data        presented bin word (registered)
//   o_m_index       bin number of o_m_data
//   o_m_last        high with bin 15
//   o_drain_done    bin-15 handshake happens this cycle
module fft_bin_serializer
  import fft_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_capture,
  input  logic [N_PTS*CPLX_W-1:0]   i_fft_out,
  input  logic                      i_m_ready,
  output logic                      o_m_valid,
  output logic [CPLX_W-1:0]         o_m_data,
  output logic [LOG2_N-1:0]         o_m_index,
  output logic                      o_m_last,
  output logic                      o_drain_done
);

  complex_t            r_buf [N_PTS];
  logic                r_valid;
  logic [CPLX_W-1:0]   r_data;
  logic [LOG2_N-1:0]   r_idx;
  logic                r_last;
  logic [LOG2_N-1:0]   w_idx_nxt;

  function automatic logic [CPLX_W-1:0] present(input complex_t b);
`ifdef FFT_MAG_EN
    logic signed [18:0] x_re;
    logic signed [18:0] x_im;
    logic [18:0]        abs_re;
    logic [18:0]        abs_im;
    logic [19:0]        sum;
    logic [17:0]        mag;
    // 19-bit intermediates so that |-2^17| = 2^17 is representable
    x_re   = 19'(b.re);
    x_im   = 19'(b.im);
    abs_re = x_re[18] ? 19'(-x_re) : 19'(x_re);
    abs_im = x_im[18] ? 19'(-x_im) : 19'(x_im);
    sum    = {1'b0, abs_re} + {1'b0, abs_im};
    mag    = (sum > 20'h3FFFF) ? 18'h3FFFF : sum[17:0];
    return {18'b0, mag};
`else
    return b;
`endif
  endfunction

  assign w_idx_nxt    = r_idx + 4'd1;
  assign o_drain_done = r_valid & r_last & i_m_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N_PTS; j++) r_buf[j] <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (i_capture) begin
      for (int j = 0; j < N_PTS; j++) r_buf[j] <= i_fft_out[j*CPLX_W +: CPLX_W];
      r_valid <= 1'b1;
      r_data  <= present(i_fft_out[0 +: CPLX_W]);
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (r_valid && i_m_ready) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_idx   <= '0;
        r_data  <= '0;
      end else begin
        r_idx  <= w_idx_nxt;
        r_data <= present(r_buf[w_idx_nxt]);
        r_last <= (w_idx_nxt == 4'(N_PTS-1));
      end
    end
  end

  assign o_m_valid = r_valid;
  assign o_m_data  = r_data;
  assign o_m_index = r_idx;
  assign o_m_last  = r_last;

endmodule

// File: rtl/fft_frame_driver.sv
// fft_frame_driver: collects 16 audio samples into a bit-reversed frame,
// launches the 16-point FFT core with a start/done level handshake and
// streams the resulting bins out through fft_bin_serializer.
// Optional build macro FFT_MAG_EN (in fft_bin_serializer): bin magnitude
// output instead of raw complex bins.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   s_valid/s_ready/s_data  sample input stream (accepted only in FILL)
//   fft_start            start level to core, held until done is seen
//   fft_in               16 x 36-bit complex input frame
//   fft_done, fft_out    core done level and its 16 output bins
//   m_valid/m_ready      bin output stream handshake
//   m_data, m_index, m_last  bin word, bin number, last-bin flag
//   busy                 high in any state other than FILL
//
// state | meaning
// FILL  | accepting samples into fft_in
// ARM   | frame complete, waiting for core done to be low (core idle)
// RUN   | fft_start held high until done; bins captured on first done
// DRAIN | serializer streaming bins; back to FILL after bin 15
module fft_frame_driver
  import fft_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int N_PTS    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [SAMPLE_W-1:0]       s_data,
  output logic                      fft_start,
  output logic [N_PTS*CPLX_W-1:0]   fft_in,
  input  logic                      fft_done,
  input  logic [N_PTS*CPLX_W-1:0]   fft_out,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CPLX_W-1:0]         m_data,
  output logic [LOG2_N-1:0]         m_index,
  output logic                      m_last,
  output logic                      busy
);

  localparam logic [LOG2_N-1:0] LAST_K = 4'(N_PTS-1);

  state_t                     r_state;
  logic [LOG2_N-1:0]          r_cnt;
  logic [N_PTS*CPLX_W-1:0]    r_fft_in;
  logic                       r_fft_start;
  logic                       r_s_ready;
  logic                       r_busy;

  logic signed [17:0]         w_re;
  logic [LOG2_N-1:0]          w_slot;
  logic                       w_xfer;
  logic                       w_capture;
  logic                       w_drain_done;

  // Sample into Q1.17: sign-extend to 18 bits, then align MSB to bit 17
  assign w_re      = 18'(signed'(s_data)) <<< (18 - SAMPLE_W);
  assign w_slot    = bitrev4(r_cnt);
  assign w_xfer    = s_valid & r_s_ready;
  assign w_capture = (r_state == RUN) & fft_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_fft_in    <= '0;
      r_fft_start <= 1'b0;
      r_s_ready   <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_xfer) begin
            for (int j = 0; j < N_PTS; j++) begin
              if (4'(j) == w_slot) r_fft_in[j*CPLX_W +: CPLX_W] <= {w_re, 18'd0};
            end
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == LAST_K) begin
              r_state   <= ARM;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
        end
        ARM: begin
          // done low means the core has finished any previous run
          if (!fft_done) begin
            r_state     <= RUN;
            r_fft_start <= 1'b1;
          end
        end
        RUN: begin
          if (fft_done) begin
            r_state     <= DRAIN;
            r_fft_start <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_state   <= FILL;
            r_cnt     <= '0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  fft_bin_serializer u_ser (
    .clk          (clk),
    .reset        (reset),
    .i_capture    (w_capture),
    .i_fft_out    (fft_out),
    .i_m_ready    (m_ready),
    .o_m_valid    (m_valid),
    .o_m_data     (m_data),
    .o_m_index    (m_index),
    .o_m_last     (m_last),
    .o_drain_done (w_drain_done)
  );

  assign s_ready   = r_s_ready;
  assign fft_start = r_fft_start;
  assign fft_in    = r_fft_in;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fft_frame_driver.sv
module tb_fft_frame_driver;

  localparam int SAMPLE_W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           s_valid;
  logic           s_ready;
  logic [15:0]    s_data;
  logic           fft_start;
  logic [575:0]   fft_in;
  logic           fft_done;
  logic [575:0]   fft_out;
  logic           m_valid;
  logic           m_ready;
  logic [35:0]    m_data;
  logic [3:0]     m_index;
  logic           m_last;
  logic           busy;

  always #5 clk = ~clk;

  fft_frame_driver #(.SAMPLE_W(SAMPLE_W), .N_PTS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .fft_start (fft_start),
    .fft_in    (fft_in),
    .fft_done  (fft_done),
    .fft_out   (fft_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .busy      (busy)
  );

  typedef struct {
    logic [35:0] data;
    logic [3:0]  idx;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_err = 0;
  int           stub_mode = 0;
  logic         force_done = 1'b0;
  logic         stub_done;
  int           stub_cnt;
  int           start_cycles = 0;
  int           sum_re;
  int           hs;
  logic [15:0]  vals [16];
  logic [35:0]  custom_bins [16];

  // Stub core: done rises 5 cycles after start rises, falls when start drops
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
    end else if (!fft_start) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
    end else if (!stub_done) begin
      if (stub_cnt == 4) stub_done <= 1'b1;
      else stub_cnt <= stub_cnt + 1;
    end
  end

  assign fft_done = stub_done | force_done;

  always @(posedge clk) if (fft_start) start_cycles <= start_cycles + 1;

  // mode 0: echo, mode 1: DC-only core (bin0 = mean of re), mode 2: fixed bins
  always_comb begin
    fft_out = '0;
    sum_re  = 0;
    case (stub_mode)
      0: fft_out = fft_in;
      1: begin
        for (int j = 0; j < 16; j++) sum_re = sum_re + int'(signed'(fft_in[j*36+18 +: 18]));
        fft_out[35:18] = 18'(sum_re >>> 4);
      end
      default: begin
        for (int j = 0; j < 16; j++) fft_out[j*36 +: 36] = custom_bins[j];
      end
    endcase
  end

  function automatic logic [3:0] rev(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  function automatic logic [17:0] fmt_re(input logic [15:0] v);
    return {v, 2'b00};
  endfunction

  function automatic logic [35:0] exp_word(input logic [17:0] re, input logic [17:0] im);
`ifdef FFT_MAG_EN
    int a;
    int b;
    int m;
    a = int'(signed'(re));
    b = int'(signed'(im));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    m = a + b;
    if (m > 262143) m = 262143;
    return 36'(m);
`else
    return {re, im};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] v);
    int t;
    t = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = v;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_n(input int n);
    for (int k = 0; k < n; k++) send(vals[k]);
  endtask

  task automatic push_echo();
    for (int j = 0; j < 16; j++)
      sb.push_back('{data: exp_word(fmt_re(vals[rev(4'(j))]), 18'd0), idx: 4'(j)});
  endtask

  // pat 0: always ready; pat 1: ready pattern 1,0,0,1 repeating
  task automatic drain(input int pat, input int max_hs, output int n_hs);
    int cyc;
    n_hs = 0;
    cyc  = 0;
    while (n_hs < max_hs && cyc < 400) begin
      @(negedge clk);
      if (m_valid) begin
        if (sb.size() > 0) begin
          chk("m_data", 64'(m_data), 64'(sb[0].data));
          chk("m_index", 64'(m_index), 64'(sb[0].idx));
          chk("m_last", 64'(m_last), 64'(sb[0].idx == 4'd15));
        end else begin
          chk("m_valid_extra", 64'(m_valid), 64'd0);
        end
      end
      m_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (m_valid && m_ready) begin
        n_hs++;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic full_drain_checks(input int pat, input string tag);
    drain(pat, 16, hs);
    chk({tag, "_handshakes"}, 64'(hs), 64'd16);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({tag, "_post_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_post_s_ready"}, 64'(s_ready), 64'd1);
    chk({tag, "_post_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    for (int j = 0; j < 16; j++) custom_bins[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fft_start", 64'(fft_start), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_index", 64'(m_index), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_fft_in_nz", 64'(|fft_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Frame A: echo core, samples 0..15
    stub_mode = 0;
    for (int k = 0; k < 16; k++) vals[k] = 16'(k);
    start_cycles = 0;
    send_n(16);
    @(negedge clk);
    chk("a_busy", 64'(busy), 64'd1);
    chk("a_s_ready", 64'(s_ready), 64'd0);
    chk("a_slot1_re", 64'(fft_in[36+18 +: 18]), 64'h20);
    chk("a_slot8_re", 64'(fft_in[8*36+18 +: 18]), 64'h4);
    chk("a_slot8_im", 64'(fft_in[8*36 +: 18]), 64'h0);
    push_echo();
    full_drain_checks(0, "a");
    chk("a_start_cycles", 64'(start_cycles), 64'd6);

    // Frame B: DC frame into DC-only core, stalled drain
    stub_mode = 1;
    for (int k = 0; k < 16; k++) vals[k] = 16'h2000;
    start_cycles = 0;
    send_n(16);
    sb.push_back('{data: exp_word(18'h08000, 18'd0), idx: 4'd0});
    for (int j = 1; j < 16; j++) sb.push_back('{data: exp_word(18'd0, 18'd0), idx: 4'(j)});
    full_drain_checks(1, "b");
    chk("b_start_cycles", 64'(start_cycles), 64'd6);

    // Frame C: random samples including extremes, stalled drain
    stub_mode = 0;
    for (int k = 0; k < 16; k++) vals[k] = 16'($urandom);
    vals[3] = 16'h8000;
    vals[5] = 16'h7FFF;
    send_n(16);
    push_echo();
    full_drain_checks(1, "c");

    // Frame D: done held high through FILL and ARM
    for (int k = 0; k < 16; k++) vals[k] = 16'(k * 37);
    @(negedge clk);
    force_done = 1'b1;
    send_n(16);
    chk("d_fill_done_ignored", 64'(m_valid), 64'd0);
    repeat (5) @(negedge clk);
    chk("d_arm_start_low", 64'(fft_start), 64'd0);
    chk("d_arm_busy", 64'(busy), 64'd1);
    force_done = 1'b0;
    start_cycles = 0;
    @(negedge clk);
    chk("d_start_rises", 64'(fft_start), 64'd1);
    push_echo();
    full_drain_checks(0, "d");
    chk("d_start_cycles", 64'(start_cycles), 64'd6);

    // Reset after 7 samples
    for (int k = 0; k < 16; k++) vals[k] = 16'(16'hF000 + k);
    send_n(7);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("r1_s_ready", 64'(s_ready), 64'd1);
    chk("r1_fft_start", 64'(fft_start), 64'd0);
    chk("r1_fft_in_nz", 64'(|fft_in), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset while the core is running
    send_n(16);
    repeat (2) @(negedge clk);
    chk("r2_start_high", 64'(fft_start), 64'd1);
    reset = 1'b1;
    #1;
    chk("r2_fft_start", 64'(fft_start), 64'd0);
    chk("r2_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-DRAIN
    for (int k = 0; k < 16; k++) vals[k] = 16'($urandom);
    send_n(16);
    push_echo();
    drain(1, 5, hs);
    chk("r3_partial_hs", 64'(hs), 64'd5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("r3_m_valid", 64'(m_valid), 64'd0);
    chk("r3_fft_start", 64'(fft_start), 64'd0);
    chk("r3_s_ready", 64'(s_ready), 64'd1);
    chk("r3_m_index", 64'(m_index), 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;

    // Frame E after resets
    for (int k = 0; k < 16; k++) vals[k] = 16'(k * 3 - 20);
    send_n(16);
    push_echo();
    full_drain_checks(0, "e");

    // Frame F: fixed bins covering magnitude corners
    stub_mode = 2;
    custom_bins[0] = {18'h3FFFD, 18'h00005};
    custom_bins[1] = {18'h1FFFF, 18'h1FFFF};
    custom_bins[2] = {18'h20000, 18'h20000};
    custom_bins[3] = {18'h20000, 18'h00000};
    for (int j = 4; j < 16; j++) custom_bins[j] = {18'(j * 1000), 18'(-j)};
    for (int k = 0; k < 16; k++) vals[k] = '0;
    send_n(16);
    for (int j = 0; j < 16; j++)
      sb.push_back('{data: exp_word(custom_bins[j][35:18], custom_bins[j][17:0]), idx: 4'(j)});
    full_drain_checks(1, "f");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
